axi_sram_top: RTL and testbench



---
 rtl/axi_sram_pkg.sv | 22 ++
 rtl/axi_sram_bridge.sv | 175 +++++++++++++++++
 rtl/axi_sram_fake_cpu.sv | 52 +++++
 rtl/axi_sram_sram.sv | 44 ++++
 rtl/axi_sram_top.sv | 59 +++++
 tb/tb_axi_sram_top.sv | 296 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/axi_sram_pkg.sv
// ---------------------------------------------------------------------------
// axi_sram_pkg
// Shared types and constants for the AXI-lite to SRAM test top:
//   - bridge_state_t : bridge FSM state encoding
//   - AXI_RESP_OKAY  : the only response code this bridge returns
//   - DEF_*          : default address/data/SRAM widths
// ---------------------------------------------------------------------------
package axi_sram_pkg;

   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_SRAM_AW = 10;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WR_RESP = 2'd1,
      ST_RD_DATA = 2'd2
   } bridge_state_t;

endpackage

// File: rtl/axi_sram_bridge.sv
// ---------------------------------------------------------------------------
// axi_sram_bridge
// AXI4-lite style slave that turns single-beat writes/reads into SRAM
// accesses. Readies are "long": held high in IDLE until their beat is taken.
// AW and W may arrive together or in either order; a write pending on either
// channel blocks AR, and a simultaneous AW/AR request is won by the write.
// Address bits above SRAM_AW+1 and the two byte-offset bits are ignored.
// Build option: define AXI_WSTRB_EN to honour wstrb per byte lane; by
// default every write updates the full word.
// Ports:
//   clk, resetn             : clock, async active-low reset
//   aw*/w*/b*/ar*/r*        : AXI-lite slave channels
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_be       : SRAM request (same-cycle)
//   mem_rdata               : SRAM read data (one cycle after request)
// ---------------------------------------------------------------------------
module axi_sram_bridge
   import axi_sram_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int SRAM_AW = DEF_SRAM_AW
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic [ADDR_W-1:0]   awaddr,
   input  logic                awvalid,
   output logic                awready,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic                wlast,
   input  logic                wvalid,
   output logic                wready,
   output logic [1:0]          bresp,
   output logic                bvalid,
   input  logic                bready,
   input  logic [ADDR_W-1:0]   araddr,
   input  logic                arvalid,
   output logic                arready,
   output logic [DATA_W-1:0]   rdata,
   output logic [1:0]          rresp,
   output logic                rlast,
   output logic                rvalid,
   input  logic                rready,
   output logic                mem_en,
   output logic                mem_we,
   output logic [SRAM_AW-1:0]  mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic [DATA_W-1:0]   mem_rdata
);

   bridge_state_t       state;
   logic                awready_q, wready_q, arready_q;
   logic                aw_done, w_done;
   logic [SRAM_AW-1:0]  waddr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W/8-1:0] wstrb_q;

   logic                aw_hs, w_hs, ar_hs, aw_now, w_now, wr_go;
   logic [SRAM_AW-1:0]  wr_idx;
   logic [DATA_W-1:0]   wr_data;
   logic [DATA_W/8-1:0] wr_strb;

   // Ready registers are only ever high in IDLE, so no state term is needed.
   assign awready = awready_q;
   assign wready  = wready_q;
   // A write request on the bus in the same cycle beats a read.
   assign arready = arready_q & ~awvalid & ~wvalid;

   assign aw_hs  = awvalid & awready_q;
   assign w_hs   = wvalid  & wready_q;
   assign ar_hs  = arvalid & arready;
   assign aw_now = aw_done | aw_hs;
   assign w_now  = w_done  | w_hs;
   assign wr_go  = (state == ST_IDLE) & aw_now & w_now;

   // Whichever beat arrives last is taken straight from the bus.
   assign wr_idx  = aw_done ? waddr_q : awaddr[SRAM_AW+1:2];
   assign wr_data = w_done  ? wdata_q : wdata;
   assign wr_strb = w_done  ? wstrb_q : wstrb;

   assign mem_en    = wr_go | ar_hs;
   assign mem_we    = wr_go;
   assign mem_addr  = ar_hs ? araddr[SRAM_AW+1:2] : wr_idx;
   assign mem_wdata = wr_data;
`ifdef AXI_WSTRB_EN
   assign mem_be    = wr_strb;
`else
   assign mem_be    = '1;
`endif

   assign rdata = mem_rdata;

   logic unused_ok;
   assign unused_ok = ^{wlast, wr_strb, awaddr[ADDR_W-1:SRAM_AW+2], awaddr[1:0],
                        araddr[ADDR_W-1:SRAM_AW+2], araddr[1:0]};

   // NOTE: all state below is updated with non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= ST_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         arready_q <= 1'b0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bvalid    <= 1'b0;
         bresp     <= AXI_RESP_OKAY;
         rvalid    <= 1'b0;
         rlast     <= 1'b0;
         rresp     <= AXI_RESP_OKAY;
      end else begin
         case (state)
            ST_IDLE: begin
               if (aw_hs) waddr_q <= awaddr[SRAM_AW+1:2];
               if (w_hs) begin
                  wdata_q <= wdata;
                  wstrb_q <= wstrb;
               end
               if (wr_go) begin
                  aw_done   <= 1'b0;
                  w_done    <= 1'b0;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b0;
                  arready_q <= 1'b0;
                  bvalid    <= 1'b1;
                  bresp     <= AXI_RESP_OKAY;
                  state     <= ST_WR_RESP;
               end else if (ar_hs) begin
                  awready_q <= 1'b0;
                  wready_q  <= 1'b0;
                  arready_q <= 1'b0;
                  rvalid    <= 1'b1;
                  rlast     <= 1'b1;
                  rresp     <= AXI_RESP_OKAY;
                  state     <= ST_RD_DATA;
               end else begin
                  // Hold a half-received write; its ready stays low and AR is locked out.
                  aw_done   <= aw_now;
                  w_done    <= w_now;
                  awready_q <= ~aw_now;
                  wready_q  <= ~w_now;
                  arready_q <= ~(aw_now | w_now);
               end
            end
            ST_WR_RESP: begin
               if (bready) begin
                  bvalid    <= 1'b0;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
                  arready_q <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            ST_RD_DATA: begin
               if (rready) begin
                  rvalid    <= 1'b0;
                  rlast     <= 1'b0;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
                  arready_q <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/axi_sram_fake_cpu.sv
// ---------------------------------------------------------------------------
// axi_sram_fake_cpu
// Logic-free AXI master stub. It only parks the master-side nets at idle
// values; the testbench overrides them with force and probes the slave-side
// nets through this instance.
// Ports:
//   master outputs : awaddr, awvalid, wdata, wstrb, wlast, wvalid, bready,
//                    araddr, arvalid, rready   (all idle, wstrb all ones)
//   slave inputs   : awready, wready, bresp, bvalid, arready, rdata, rresp,
//                    rlast, rvalid             (observed only)
// ---------------------------------------------------------------------------
module axi_sram_fake_cpu #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   output logic [ADDR_W-1:0]   awaddr,
   output logic                awvalid,
   input  logic                awready,
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   output logic                wlast,
   output logic                wvalid,
   input  logic                wready,
   input  logic [1:0]          bresp,
   input  logic                bvalid,
   output logic                bready,
   output logic [ADDR_W-1:0]   araddr,
   output logic                arvalid,
   input  logic                arready,
   input  logic [DATA_W-1:0]   rdata,
   input  logic [1:0]          rresp,
   input  logic                rlast,
   input  logic                rvalid,
   output logic                rready
);

   assign awaddr  = '0;
   assign awvalid = 1'b0;
   assign wdata   = '0;
   assign wstrb   = '1;
   assign wlast   = 1'b0;
   assign wvalid  = 1'b0;
   assign bready  = 1'b0;
   assign araddr  = '0;
   assign arvalid = 1'b0;
   assign rready  = 1'b0;

   // Slave-side nets are only probed from outside this stub.
   logic unused_ok;
   assign unused_ok = ^{awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid};

endmodule

// File: rtl/axi_sram_sram.sv
// ---------------------------------------------------------------------------
// axi_sram_sram
// Single-port synchronous SRAM, 2**SRAM_AW words, per-byte write enables,
// one-cycle read latency. Contents are never cleared; only the read data
// register is reset.
// Ports:
//   clk, resetn : clock, async active-low reset (read register only)
//   en, we      : access enable, write (1) / read (0)
//   addr        : word address
//   wdata, be   : write data and byte-lane enables
//   rdata       : registered read data, holds until the next read
// ---------------------------------------------------------------------------
module axi_sram_sram #(
   parameter int DATA_W  = 32,
   parameter int SRAM_AW = 10
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                en,
   input  logic                we,
   input  logic [SRAM_AW-1:0]  addr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] be,
   output logic [DATA_W-1:0]   rdata
);

   logic [DATA_W-1:0] mem [2**SRAM_AW];

   // NOTE: the array deliberately has no reset; contents survive resetn and
   // a reset branch here would turn the RAM into a huge bank of flops.
   always_ff @(posedge clk) begin
      if (en && we) begin
         for (int b = 0; b < DATA_W/8; b++) begin
            if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)          rdata <= '0;
      else if (en && !we)   rdata <= mem[addr];
   end

endmodule

// File: rtl/axi_sram_top.sv
// ---------------------------------------------------------------------------
// axi_sram_top
// Self-contained simulation vehicle: master stub (fake_cpu) -> AXI-lite to
// SRAM bridge (u_bridge) -> single-port SRAM (u_sram). Traffic is injected by
// forcing the master-side nets of fake_cpu.
// Build option: AXI_WSTRB_EN enables per-byte write strobes in the bridge.
// Ports:
//   clk    : system clock, rising edge
//   resetn : asynchronous active-low reset
// ---------------------------------------------------------------------------
module axi_sram_top
   import axi_sram_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int SRAM_AW = DEF_SRAM_AW
) (
   input logic clk,
   input logic resetn
);

   logic [ADDR_W-1:0]   awaddr, araddr;
   logic                awvalid, awready, wlast, wvalid, wready;
   logic                bvalid, bready, arvalid, arready, rlast, rvalid, rready;
   logic [DATA_W-1:0]   wdata, rdata;
   logic [DATA_W/8-1:0] wstrb;
   logic [1:0]          bresp, rresp;

   logic                mem_en, mem_we;
   logic [SRAM_AW-1:0]  mem_addr;
   logic [DATA_W-1:0]   mem_wdata, mem_rdata;
   logic [DATA_W/8-1:0] mem_be;

   axi_sram_fake_cpu #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) fake_cpu (
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   axi_sram_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRAM_AW(SRAM_AW)) u_bridge (
      .clk(clk), .resetn(resetn),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
   );

   axi_sram_sram #(.DATA_W(DATA_W), .SRAM_AW(SRAM_AW)) u_sram (
      .clk(clk), .resetn(resetn),
      .en(mem_en), .we(mem_we), .addr(mem_addr),
      .wdata(mem_wdata), .be(mem_be), .rdata(mem_rdata)
   );

endmodule

// File: tb/tb_axi_sram_top.sv
// ---------------------------------------------------------------------------
// tb_axi_sram_top
// Drives AXI-lite traffic into axi_sram_top by forcing the fake_cpu master
// nets and probing its slave-side nets. Inputs change on the falling edge;
// outputs are sampled on the falling edge or 1 unit after an input change.
// Read data is checked against a scoreboard queue filled from a word model.
// ---------------------------------------------------------------------------
module tb_axi_sram_top;

   localparam int SRAM_AW = 10;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   axi_sram_top dut (.clk(clk), .resetn(resetn));

   int checks = 0;
   int failures = 0;

   logic [31:0] model [int];
   logic [31:0] exp_q [$];

   logic [31:0] m_awaddr = '0, m_araddr = '0, m_wdata = '0;
   logic [3:0]  m_wstrb = 4'hF;
   logic        m_awvalid = 0, m_wvalid = 0, m_wlast = 0, m_bready = 0, m_arvalid = 0, m_rready = 0;

   task automatic apply();
      force dut.fake_cpu.awaddr  = m_awaddr;
      force dut.fake_cpu.awvalid = m_awvalid;
      force dut.fake_cpu.wdata   = m_wdata;
      force dut.fake_cpu.wstrb   = m_wstrb;
      force dut.fake_cpu.wlast   = m_wlast;
      force dut.fake_cpu.wvalid  = m_wvalid;
      force dut.fake_cpu.bready  = m_bready;
      force dut.fake_cpu.araddr  = m_araddr;
      force dut.fake_cpu.arvalid = m_arvalid;
      force dut.fake_cpu.rready  = m_rready;
   endtask

   function automatic int widx(input logic [31:0] a);
      return int'(a[SRAM_AW+1:2]);
   endfunction

   task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      logic [31:0] w;
      int idx;
      idx = widx(addr);
      w = model.exists(idx) ? model[idx] : 32'h0;
`ifdef AXI_WSTRB_EN
      for (int b = 0; b < 4; b++) if (strb[b]) w[b*8 +: 8] = data[b*8 +: 8];
`else
      w = data;
      if (strb == 4'h0) w = data;
`endif
      model[idx] = w;
   endtask

   // Issue AW at once and W after w_delay cycles; drop each valid after its handshake.
   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int w_delay, input string name);
      bit aw_ok = 0, w_ok = 0, aw_hs, w_hs, bad_pending = 0;
      m_awaddr = addr; m_awvalid = 1; m_wdata = data; m_wstrb = strb; m_wlast = 1;
      m_wvalid = (w_delay == 0);
      apply();
      for (int c = 0; c < 30 && !(aw_ok && w_ok); c++) begin
         #1;
         aw_hs = m_awvalid && dut.fake_cpu.awready;
         w_hs  = m_wvalid && dut.fake_cpu.wready;
         if (aw_ok && !w_ok && (dut.fake_cpu.bvalid || dut.fake_cpu.awready || dut.fake_cpu.arready))
            bad_pending = 1;
         @(negedge clk);
         if (aw_hs) begin aw_ok = 1; m_awvalid = 0; end
         if (w_hs)  begin w_ok = 1;  m_wvalid = 0;  end
         if (c + 1 == w_delay && !w_ok) m_wvalid = 1;
         apply();
      end
      checks++;
      if (!(aw_ok && w_ok)) begin
         failures++;
         $display("FAIL %s_handshake aw=%0b w=%0b required both 1", name, aw_ok, w_ok);
      end else begin
         model_write(addr, data, strb);
      end
      if (w_delay > 0) begin
         checks++;
         if (bad_pending) begin
            failures++;
            $display("FAIL %s_pending bvalid/awready/arready seen high while W outstanding, required all 0", name);
         end
      end
   endtask

   task automatic wait_bresp(input int hold, input string name);
      int c = 0;
      while (dut.fake_cpu.bvalid !== 1'b1 && c < 20) begin @(negedge clk); c++; end
      checks++;
      if (dut.fake_cpu.bvalid !== 1'b1 || dut.fake_cpu.bresp !== 2'b00) begin
         failures++;
         $display("FAIL %s_bresp bvalid=%b bresp=%b required 1/00", name, dut.fake_cpu.bvalid, dut.fake_cpu.bresp);
      end
      if (hold > 0) begin
         repeat (hold) @(negedge clk);
         checks++;
         if (dut.fake_cpu.bvalid !== 1'b1) begin
            failures++;
            $display("FAIL %s_bvalid_held bvalid=%b required 1", name, dut.fake_cpu.bvalid);
         end
      end
      m_bready = 1; apply();
      @(negedge clk);
      m_bready = 0; apply();
      checks++;
      if ({dut.fake_cpu.bvalid, dut.fake_cpu.awready, dut.fake_cpu.wready} !== 3'b011) begin
         failures++;
         $display("FAIL %s_b_done bvalid/awready/wready=%b required 011", name,
                  {dut.fake_cpu.bvalid, dut.fake_cpu.awready, dut.fake_cpu.wready});
      end
   endtask

   task automatic do_read(input logic [31:0] addr, input int rready_delay, input string name);
      bit hs = 0;
      logic [31:0] exp_d = '0;
      m_araddr = addr; m_arvalid = 1; m_rready = (rready_delay == 0);
      apply();
      for (int c = 0; c < 20 && !hs; c++) begin
         #1;
         if (dut.fake_cpu.arready === 1'b1) hs = 1;
         @(negedge clk);
      end
      if (hs) exp_q.push_back(model[widx(addr)]);
      m_arvalid = 0; apply();
      checks++;
      if (!hs || {dut.fake_cpu.rvalid, dut.fake_cpu.rlast, dut.fake_cpu.rresp} !== 4'b1100) begin
         failures++;
         $display("FAIL %s_rvalid ar_hs=%0b rvalid/rlast/rresp=%b required 1/1100", name, hs,
                  {dut.fake_cpu.rvalid, dut.fake_cpu.rlast, dut.fake_cpu.rresp});
      end
      if (exp_q.size() > 0) begin
         exp_d = exp_q.pop_front();
         checks++;
         if (dut.fake_cpu.rdata !== exp_d) begin
            failures++;
            $display("FAIL %s_rdata got=%h required=%h", name, dut.fake_cpu.rdata, exp_d);
         end
      end
      if (rready_delay > 0) begin
         repeat (rready_delay) @(negedge clk);
         checks++;
         if (dut.fake_cpu.rvalid !== 1'b1 || dut.fake_cpu.rdata !== exp_d) begin
            failures++;
            $display("FAIL %s_r_held rvalid=%b rdata=%h required 1/%h", name,
                     dut.fake_cpu.rvalid, dut.fake_cpu.rdata, exp_d);
         end
         m_rready = 1; apply();
      end
      @(negedge clk);
      m_rready = 0; apply();
      checks++;
      if (dut.fake_cpu.rvalid !== 1'b0) begin
         failures++;
         $display("FAIL %s_r_done rvalid=%b required 0", name, dut.fake_cpu.rvalid);
      end
   endtask

   task automatic test_reset();
      resetn = 0;
      apply();
      #16;
      checks++;
      if ({dut.fake_cpu.awready, dut.fake_cpu.wready, dut.fake_cpu.arready,
           dut.fake_cpu.bvalid, dut.fake_cpu.rvalid} !== 5'b0) begin
         failures++;
         $display("FAIL reset_ctrl aw/w/ar ready,bvalid,rvalid=%b required 00000",
                  {dut.fake_cpu.awready, dut.fake_cpu.wready, dut.fake_cpu.arready,
                   dut.fake_cpu.bvalid, dut.fake_cpu.rvalid});
      end
      checks++;
      if ({dut.fake_cpu.rdata, dut.fake_cpu.bresp, dut.fake_cpu.rresp} !== 36'h0) begin
         failures++;
         $display("FAIL reset_data rdata=%h bresp=%b rresp=%b required 0", dut.fake_cpu.rdata,
                  dut.fake_cpu.bresp, dut.fake_cpu.rresp);
      end
      #16;
      resetn = 1;
      @(negedge clk);
      checks++;
      if ({dut.fake_cpu.awready, dut.fake_cpu.wready, dut.fake_cpu.arready} !== 3'b111) begin
         failures++;
         $display("FAIL reset_release readies=%b required 111",
                  {dut.fake_cpu.awready, dut.fake_cpu.wready, dut.fake_cpu.arready});
      end
   endtask

   task automatic test_basic();
      do_write(32'h4, 32'habcdaaaa, 4'hF, 0, "basic_wr");
      wait_bresp(5, "basic_wr");
      do_read(32'h4, 0, "basic_rd");
   endtask

   task automatic test_late_w();
      do_write(32'h20, 32'h5a5a1234, 4'hF, 3, "late_w");
      wait_bresp(1, "late_w");
      do_read(32'h20, 2, "late_w_rd");
   endtask

   task automatic test_arbitration();
      m_awaddr = 32'h8; m_awvalid = 1; m_wdata = 32'h12345678; m_wstrb = 4'hF; m_wlast = 1; m_wvalid = 1;
      m_araddr = 32'h8; m_arvalid = 1; m_rready = 1;
      apply();
      #1;
      checks++;
      if ({dut.fake_cpu.awready, dut.fake_cpu.wready, dut.fake_cpu.arready} !== 3'b110) begin
         failures++;
         $display("FAIL arb_ready aw/w/ar ready=%b required 110",
                  {dut.fake_cpu.awready, dut.fake_cpu.wready, dut.fake_cpu.arready});
      end
      @(negedge clk);
      model_write(32'h8, 32'h12345678, 4'hF);
      m_awvalid = 0; m_wvalid = 0; apply();
      checks++;
      if ({dut.fake_cpu.bvalid, dut.fake_cpu.rvalid} !== 2'b10) begin
         failures++;
         $display("FAIL arb_write_first bvalid/rvalid=%b required 10", {dut.fake_cpu.bvalid, dut.fake_cpu.rvalid});
      end
      wait_bresp(0, "arb_wr");
      do_read(32'h8, 0, "arb_rd");
   endtask

   task automatic test_alias();
      do_write(32'h4 | (32'h1 << (SRAM_AW + 2)), 32'hcafef00d, 4'hF, 0, "alias_wr");
      wait_bresp(0, "alias_wr");
      do_read(32'h4, 0, "alias_rd");
   endtask

   task automatic test_reset_mid();
      m_awaddr = 32'h30; m_awvalid = 1; apply();
      @(negedge clk);
      m_awvalid = 0; apply();
      #1;
      checks++;
      if ({dut.fake_cpu.awready, dut.fake_cpu.wready, dut.fake_cpu.arready} !== 3'b010) begin
         failures++;
         $display("FAIL mid_aw_only readies=%b required 010",
                  {dut.fake_cpu.awready, dut.fake_cpu.wready, dut.fake_cpu.arready});
      end
      #1 resetn = 0;
      #1;
      checks++;
      if ({dut.fake_cpu.awready, dut.fake_cpu.wready, dut.fake_cpu.arready, dut.fake_cpu.bvalid} !== 4'b0) begin
         failures++;
         $display("FAIL mid_reset readies/bvalid=%b required 0000",
                  {dut.fake_cpu.awready, dut.fake_cpu.wready, dut.fake_cpu.arready, dut.fake_cpu.bvalid});
      end
      #1 resetn = 1;
      @(negedge clk);
      checks++;
      if ({dut.fake_cpu.awready, dut.fake_cpu.wready, dut.fake_cpu.arready} !== 3'b111) begin
         failures++;
         $display("FAIL mid_flags_cleared readies=%b required 111",
                  {dut.fake_cpu.awready, dut.fake_cpu.wready, dut.fake_cpu.arready});
      end
      do_read(32'h4, 0, "mid_retained");
   endtask

`ifdef AXI_WSTRB_EN
   task automatic test_wstrb();
      do_write(32'h10, 32'hffffffff, 4'hF, 0, "strb_full");
      wait_bresp(0, "strb_full");
      do_write(32'h10, 32'h00000000, 4'b0011, 0, "strb_low");
      wait_bresp(0, "strb_low");
      do_read(32'h10, 0, "strb_rd");
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_late_w();
      test_arbitration();
      test_alias();
      test_reset_mid();
`ifdef AXI_WSTRB_EN
      test_wstrb();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
